apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 126 ++++++++++++
 tb/tb_apb_master.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// apb_master: single-transfer APB master driving two slaves, with a bounded wait-state timeout.
//   PCLK, PRESETn          bus clock, async active-low reset
//   req, wr, addr, wdata   user request (addr[8] picks slave 2), sampled while idle
//   busy, done, err, rdata transfer status, one-cycle completion pulse, timeout flag, read data
//   PSEL1/2, PENABLE, PWRITE, PADDR, PWDATA   APB request side
//   PRDATA1/2, PREADY1/2   APB slave responses
module apb_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       req,
    input  logic       wr,
    input  logic [8:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] rdata,
    output logic       PSEL1,
    output logic       PSEL2,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [8:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA1,
    input  logic [7:0] PRDATA2,
    input  logic       PREADY1,
    input  logic       PREADY2
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic       psel1_n, psel2_n, penable_n, pwrite_n, done_n, err_n, busy_n;
    logic [8:0] paddr_n;
    logic [7:0] pwdata_n, rdata_n;
    logic       ready;
    logic [7:0] prdata;

    // Only the selected slave's response is ever looked at.
    assign ready  = PSEL2 ? PREADY2 : PREADY1;
    assign prdata = PSEL2 ? PRDATA2 : PRDATA1;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        psel1_n   = PSEL1;
        psel2_n   = PSEL2;
        penable_n = PENABLE;
        pwrite_n  = PWRITE;
        paddr_n   = PADDR;
        pwdata_n  = PWDATA;
        rdata_n   = rdata;
        busy_n    = busy;
        done_n    = 1'b0;
        err_n     = 1'b0;
        case (state)
            IDLE: begin
                // The done cycle is spent in IDLE; a request seen there is dropped.
                if (req && !done) begin
                    state_n  = SETUP;
                    pwrite_n = wr;
                    paddr_n  = addr;
                    pwdata_n = wdata;
                    psel1_n  = !addr[8];
                    psel2_n  = addr[8];
                    busy_n   = 1'b1;
                end
            end
            SETUP: begin
                state_n   = ACCESS;
                penable_n = 1'b1;
                cnt_n     = 8'd0;
            end
            ACCESS: begin
                // Ready wins over the timeout when both happen on the same edge.
                if (ready || cnt == LAST) begin
                    state_n   = IDLE;
                    psel1_n   = 1'b0;
                    psel2_n   = 1'b0;
                    penable_n = 1'b0;
                    busy_n    = 1'b0;
                    done_n    = 1'b1;
                    err_n     = !ready;
                    rdata_n   = (ready && !PWRITE) ? prdata : rdata;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            PSEL1   <= 1'b0;
            PSEL2   <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= 9'd0;
            PWDATA  <= 8'd0;
            rdata   <= 8'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            PSEL1   <= psel1_n;
            PSEL2   <= psel2_n;
            PENABLE <= penable_n;
            PWRITE  <= pwrite_n;
            PADDR   <= paddr_n;
            PWDATA  <= pwdata_n;
            rdata   <= rdata_n;
            busy    <= busy_n;
            done    <= done_n;
            err     <= err_n;
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed vector bench for apb_master with two modelled slaves.
module tb_apb_master;
    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       req = 1'b0;
    logic       wr = 1'b0;
    logic [8:0] addr = 9'd0;
    logic [7:0] wdata = 8'd0;
    logic       busy, done, err;
    logic [7:0] rdata;
    logic       PSEL1, PSEL2, PENABLE, PWRITE;
    logic [8:0] PADDR;
    logic [7:0] PWDATA, PRDATA1, PRDATA2;
    logic       PREADY1, PREADY2;

    always #5 PCLK = ~PCLK;

    apb_master #(.TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata),
        .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2),
        .PREADY1(PREADY1), .PREADY2(PREADY2)
    );

    // Slaves: ready after w ACCESS cycles; slave 1 can also have PREADY tied high.
    logic [7:0] mem1 [256];
    logic [7:0] mem2 [256];
    logic       init_mem = 1'b0;
    logic       tie1 = 1'b0;
    int         w1 = 0, w2 = 0, acc = 0;

    assign PREADY1 = tie1 || (PSEL1 && PENABLE && acc >= w1);
    assign PREADY2 = PSEL2 && PENABLE && acc >= w2;
    assign PRDATA1 = mem1[PADDR[7:0]];
    assign PRDATA2 = mem2[PADDR[7:0]];

    always @(posedge PCLK) begin
        acc <= (PENABLE && !(PSEL2 ? PREADY2 : PREADY1)) ? acc + 1 : 0;
        if (init_mem) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= 8'(i);
                mem2[i] <= ~8'(i);
            end
        end else begin
            if (PSEL1 && PENABLE && PREADY1 && PWRITE) mem1[PADDR[7:0]] <= PWDATA;
            if (PSEL2 && PENABLE && PREADY2 && PWRITE) mem2[PADDR[7:0]] <= PWDATA;
        end
    end

    typedef struct {
        logic       wr;
        logic [8:0] addr;
        logic [7:0] wdata;
        int         w1;
        int         w2;
        logic       tie1;
        int         cyc;
        logic       err;
        logic [7:0] rd;
    } vec_t;

    vec_t v [8];
    int   tests = 0, fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t t, input int idx, input bit sync);
        int n, ns, ne, bad;
        if (sync) @(negedge PCLK);
        w1 = t.w1; w2 = t.w2; tie1 = t.tie1;
        req = 1'b1; wr = t.wr; addr = t.addr; wdata = t.wdata;
        @(posedge PCLK);
        #1;
        req = 1'b0; wr = ~t.wr; addr = ~t.addr; wdata = ~t.wdata;
        n = 0; ns = 0; ne = 0; bad = 0;
        do begin
            @(negedge PCLK);
            n++;
            if (!done) begin
                ns += int'(PSEL1 | PSEL2);
                ne += int'(PENABLE);
                if (PSEL1 !== !t.addr[8] || PSEL2 !== t.addr[8] || PADDR !== t.addr ||
                    PWRITE !== t.wr || PWDATA !== t.wdata || busy !== 1'b1 ||
                    PENABLE !== (n != 1)) bad++;
            end
        end while (!done && n < 40);
        chk($sformatf("v%0d cycles", idx), n, t.cyc);
        chk($sformatf("v%0d bus_stable", idx), bad, 0);
        chk($sformatf("v%0d psel_cycles", idx), ns, t.cyc - 1);
        chk($sformatf("v%0d access_cycles", idx), ne, t.cyc - 2);
        chk($sformatf("v%0d err", idx), err, t.err);
        chk($sformatf("v%0d rdata", idx), rdata, t.rd);
        chk($sformatf("v%0d done_quiet", idx), {PSEL1, PSEL2, PENABLE, busy}, 4'b0000);
        chk($sformatf("v%0d hold_addr", idx), {PADDR, PWRITE, PWDATA}, {t.addr, t.wr, t.wdata});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] pat_s, pat_d, pat_x;
        v[0] = '{1'b1, 9'h1A5, 8'h3C, 0,  1,    1'b0, 4,  1'b0, 8'h00};
        v[1] = '{1'b0, 9'h1A5, 8'h00, 0,  1,    1'b0, 4,  1'b0, 8'h3C};
        v[2] = '{1'b1, 9'h010, 8'h5A, 0,  0,    1'b1, 3,  1'b0, 8'h3C};
        v[3] = '{1'b0, 9'h010, 8'h00, 0,  0,    1'b0, 3,  1'b0, 8'h5A};
        v[4] = '{1'b0, 9'h110, 8'h00, 0,  2,    1'b1, 5,  1'b0, 8'hEF};
        v[5] = '{1'b0, 9'h1A5, 8'h00, 0,  1000, 1'b0, 18, 1'b1, 8'hEF};
        v[6] = '{1'b0, 9'h0FF, 8'h00, 15, 0,    1'b0, 18, 1'b0, 8'hFF};
        v[7] = '{1'b1, 9'h000, 8'h81, 0,  0,    1'b0, 3,  1'b0, 8'hFF};

        #2;
        chk("reset_outputs", {PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, rdata, done, err, busy}, 32'd0);
        init_mem = 1'b1;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        init_mem = 1'b0;
        PRESETn = 1'b1;
        run(v[0], 0, 1'b0);
        chk("slave2_mem_a5", mem2[8'hA5], 8'h3C);
        for (int i = 1; i < 8; i++) run(v[i], i, 1'b1);
        chk("slave1_mem_10", mem1[8'h10], 8'h5A);

        @(negedge PCLK);
        w1 = 0; tie1 = 1'b0; req = 1'b1; wr = 1'b0; addr = 9'h010;
        for (int i = 0; i < 8; i++) begin
            @(negedge PCLK);
            pat_s[i] = PSEL1;
            pat_d[i] = done;
            pat_x[i] = PSEL2;
        end
        req = 1'b0;
        chk("held_req_psel1", pat_s, 8'b0011_0011);
        chk("held_req_done", pat_d, 8'b0100_0100);
        chk("held_req_psel2", pat_x, 8'h00);

        @(negedge PCLK);
        w2 = 1000; req = 1'b1; wr = 1'b1; addr = 9'h155; wdata = 8'h99;
        @(posedge PCLK);
        #1;
        req = 1'b0;
        repeat (2) @(negedge PCLK);
        chk("pre_reset_access", {PENABLE, PSEL2}, 2'b11);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("async_reset_outputs", {PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, rdata, done, err, busy}, 32'd0);
        @(negedge PCLK);
        chk("reset_no_done", {done, busy, PSEL2}, 3'b000);
        chk("reset_no_write", mem2[8'h55], 8'hAA);
        PRESETn = 1'b1;
        run(v[3], 8, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
